// File: rtl/mgmt_gpio_pkg.sv
// Shared definitions for the management GPIO pad arbiter.
//   - Default requester count and the fixed requester slot assignment.
//   - FSM state encoding used by the arbiter top.
//   - Helper that sizes requester index fields.
package mgmt_gpio_pkg;

  localparam int NREQ_DEF = 3;

  // Requester slots. After reset, slot 0 (the CPU CSR path) wins the first
  // arbitration.
  localparam int REQ_CPU = 0;
  localparam int REQ_LA  = 1;
  localparam int REQ_HK  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  // Width of a requester index. It is never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mgmt_gpio_rr_pick.sv
// Combinational round-robin selector.
//   mask        : eligible requesters (request and not blocked)
//   last_owner  : index of the most recent owner; the scan starts just after it
//   pick        : index of the first eligible requester after last_owner, with wrap
//   valid       : 1 when any requester is eligible
module mgmt_gpio_rr_pick
  import mgmt_gpio_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  localparam int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] last_owner,
  output logic [IDX_W-1:0] pick,
  output logic             valid
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    // The scan runs from the farthest candidate back to the nearest. The
    // nearest eligible requester after last_owner is assigned last, so it wins.
    for (int i = NREQ; i >= 1; i--) begin
      if (mask[(int'(last_owner) + i) % NREQ]) begin
        pick  = IDX_W'((int'(last_owner) + i) % NREQ);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mgmt_gpio_arbiter.sv
// Arbiter for the single management GPIO pad. It shares the pad among NREQ requesters
// (CPU CSR, logic-analyzer override, housekeeping). It also synchronises the pad input
// back to all of them.
//   core_clk, core_rstn : clock, asynchronous active-low reset
//   req                 : level ownership request, one bit per requester
//   out_val, oe_val     : per-requester pad value and output enable (1 = drive)
//   tmo_cycles          : watchdog grant limit in cycles, 0 disables it
//   gnt                 : registered one-hot grant
//   gpio_out, gpio_oeb  : registered pad value and active-low pad enable
//   gpio_in_pad         : raw asynchronous pad input
//   gpio_in             : pad input after SYNC_STG flops
//   busy                : high whenever the arbiter is not idle
//   tmo_evt             : one-cycle pulse when the watchdog revokes a grant
module mgmt_gpio_arbiter
  import mgmt_gpio_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int TMO_W    = 16,
  parameter int SYNC_STG = 2
) (
  input  logic             core_clk,
  input  logic             core_rstn,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  out_val,
  input  logic [NREQ-1:0]  oe_val,
  input  logic [TMO_W-1:0] tmo_cycles,
  output logic [NREQ-1:0]  gnt,
  output logic             gpio_out,
  output logic             gpio_oeb,
  input  logic             gpio_in_pad,
  output logic             gpio_in,
  output logic             busy,
  output logic             tmo_evt
);

  localparam int IDX_W = idx_w(NREQ);

  state_t             state_q, state_nxt;
  logic [IDX_W-1:0]   owner_q, owner_nxt;   // last/current owner
  logic [TMO_W-1:0]   cnt_q, cnt_nxt;
  logic [NREQ-1:0]    block_q, block_nxt;
  logic [NREQ-1:0]    gnt_nxt;
  logic               out_nxt, oeb_nxt, evt_nxt;
  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic               released, expired;
  logic [SYNC_STG-1:0] sync_q;

  mgmt_gpio_rr_pick #(.NREQ(NREQ)) u_pick (
    .mask       (req & ~block_q),
    .last_owner (owner_q),
    .pick       (pick),
    .valid      (pick_valid)
  );

  assign released = ~req[owner_q];
  // The limit is compared against the live tmo_cycles. A mid-grant change
  // applies at once to the running count.
  assign expired  = (tmo_cycles != '0) && (cnt_q == tmo_cycles - TMO_W'(1));
  assign busy     = (state_q != ST_IDLE);
  assign gpio_in  = sync_q[SYNC_STG-1];

  always_comb begin
    state_nxt = state_q;
    owner_nxt = owner_q;
    cnt_nxt   = cnt_q;
    gnt_nxt   = gnt;
    out_nxt   = gpio_out;
    oeb_nxt   = 1'b1;
    evt_nxt   = 1'b0;
    // A revoked requester stays blocked only while it keeps requesting.
    block_nxt = block_q & req;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = NREQ'(1) << pick;
          owner_nxt = pick;
          cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        out_nxt = out_val[owner_q];
        if (released || expired) begin
          // A release in the same cycle as a timeout counts as a normal
          // release. The owner is not penalised.
          state_nxt = ST_DEAD;
          gnt_nxt   = '0;
          if (!released) begin
            evt_nxt            = 1'b1;
            block_nxt[owner_q] = 1'b1;
          end
        end else begin
          oeb_nxt = ~oe_val[owner_q];
          if (cnt_q != '1) cnt_nxt = cnt_q + TMO_W'(1);
        end
      end
      ST_DEAD: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments. All flops then
  // sample the values they had before the edge, whatever order the statements are in.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q  <= ST_IDLE;
      owner_q  <= IDX_W'(NREQ - 1);
      cnt_q    <= '0;
      block_q  <= '0;
      gnt      <= '0;
      gpio_out <= 1'b0;
      gpio_oeb <= 1'b1;
      tmo_evt  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      owner_q  <= owner_nxt;
      cnt_q    <= cnt_nxt;
      block_q  <= block_nxt;
      gnt      <= gnt_nxt;
      gpio_out <= out_nxt;
      gpio_oeb <= oeb_nxt;
      tmo_evt  <= evt_nxt;
    end
  end

  // The pad input is asynchronous. The first flop can go metastable, and the
  // later stages give it time to settle.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) sync_q <= '0;
    else            sync_q <= {sync_q[SYNC_STG-2:0], gpio_in_pad};
  end

endmodule

// File: tb/tb_mgmt_gpio_arbiter.sv
// Scoreboard bench for mgmt_gpio_arbiter. The driver applies inputs on the falling
// edge and queues the expected outputs from an ownership-level reference model.
// The monitor pops one expectation after each rising edge and compares it.
module tb_mgmt_gpio_arbiter;
  import mgmt_gpio_pkg::*;

  localparam int N            = 3;
  localparam int TMO_W        = 16;
  localparam int STG          = 2;
  localparam int MAXCNT       = (1 << TMO_W) - 1;
  localparam int STARVE_BOUND = 500;

  logic             core_clk = 1'b0;
  logic             core_rstn;
  logic [N-1:0]     req, out_val, oe_val;
  logic [TMO_W-1:0] tmo_cycles;
  logic             gpio_in_pad;
  logic [N-1:0]     gnt;
  logic             gpio_out, gpio_oeb, gpio_in, busy, tmo_evt;

  always #5 core_clk = ~core_clk;

  mgmt_gpio_arbiter #(.NREQ(N), .TMO_W(TMO_W), .SYNC_STG(STG)) dut (
    .core_clk    (core_clk),
    .core_rstn   (core_rstn),
    .req         (req),
    .out_val     (out_val),
    .oe_val      (oe_val),
    .tmo_cycles  (tmo_cycles),
    .gnt         (gnt),
    .gpio_out    (gpio_out),
    .gpio_oeb    (gpio_oeb),
    .gpio_in_pad (gpio_in_pad),
    .gpio_in     (gpio_in),
    .busy        (busy),
    .tmo_evt     (tmo_evt)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         out;
    logic         oeb;
    logic         busy;
    logic         evt;
    logic         gin;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   starve_en = 1'b0;
  int   wait_c[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model. It tracks who owns the pad, whether the hand-over gap is
  // running, how long the current grant has lasted, and which requesters lost
  // a grant to the watchdog.
  int       m_owner;   // -1: nobody holds the pad
  int       m_gap;     // remaining non-owner cycles before arbitration
  int       m_last;
  bit [N-1:0] m_blk;
  int       m_len;
  bit       m_out, m_oeb, m_evt;
  bit       m_hist[$];

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_last = N - 1; m_blk = '0; m_len = 0;
    m_out = 1'b0; m_oeb = 1'b1; m_evt = 1'b0;
    m_hist = {};
    for (int i = 0; i < STG - 1; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_step(output exp_t e);
    bit [N-1:0] blk_next;
    bit rel, tmo_hit, gin;
    blk_next = m_blk & req;
    m_evt    = 1'b0;
    if (m_owner >= 0) begin
      rel     = !req[m_owner];
      tmo_hit = (tmo_cycles != 0) && (m_len == int'(tmo_cycles) - 1);
      m_out   = out_val[m_owner];
      if (rel || tmo_hit) begin
        if (!rel) begin
          m_evt = 1'b1;
          blk_next[m_owner] = 1'b1;
        end
        m_owner = -1;
        m_gap   = 1;
        m_oeb   = 1'b1;
      end else begin
        m_oeb = !oe_val[m_owner];
        if (m_len < MAXCNT) m_len++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      m_oeb = 1'b1;
    end else begin
      m_oeb = 1'b1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req[c] && !m_blk[c]) begin
          m_owner = c; m_last = c; m_len = 0;
          break;
        end
      end
    end
    m_blk = blk_next;
    m_hist.push_back(gpio_in_pad);
    gin = m_hist.pop_front();
    e.gnt  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.out  = m_out;
    e.oeb  = m_oeb;
    e.busy = (m_owner >= 0) || (m_gap > 0);
    e.evt  = m_evt;
    e.gin  = gin;
  endtask

  // Drives one cycle of stimulus and queues its expectation. It returns just
  // after the following rising edge, once the monitor has compared.
  task automatic tick(input logic [N-1:0] r, input logic [N-1:0] o, input logic [N-1:0] oe,
                      input logic [TMO_W-1:0] t, input logic pad);
    exp_t e;
    @(negedge core_clk);
    req = r; out_val = o; oe_val = oe; tmo_cycles = t; gpio_in_pad = pad;
    model_step(e);
    exp_q.push_back(e);
    @(posedge core_clk);
    #2;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge core_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",      gnt,      e.gnt);
        check("gpio_out", gpio_out, e.out);
        check("gpio_oeb", gpio_oeb, e.oeb);
        check("busy",     busy,     e.busy);
        check("tmo_evt",  tmo_evt,  e.evt);
        check("gpio_in",  gpio_in,  e.gin);
        check("gnt_onehot0", $onehot0(gnt), 1);
        check("oeb_when_idle", (gnt == '0) ? gpio_oeb : 1'b1, 1);
      end
      for (int i = 0; i < N; i++) begin
        if (!starve_en) wait_c[i] = 0;
        else if (gnt[i]) begin
          check("starve_wait", wait_c[i] < STARVE_BOUND, 1);
          wait_c[i] = 0;
        end else if (req[i]) wait_c[i]++;
        else wait_c[i] = 0;
      end
    end
  end

  logic [N-1:0] r_rand, flip;
  logic [TMO_W-1:0] t_rand;

  initial begin
    core_rstn = 1'b0; req = '0; out_val = '0; oe_val = '0;
    tmo_cycles = '0; gpio_in_pad = 1'b0;
    model_reset();
    repeat (3) @(posedge core_clk);
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_out", gpio_out, 0);
    check("rst_oeb", gpio_oeb, 1);
    check("rst_busy", busy, 0);
    check("rst_evt", tmo_evt, 0);
    check("rst_gin", gpio_in, 0);
    @(negedge core_clk);
    core_rstn = 1'b1;

    // Round robin after reset, with the pad following owner 0.
    tick(3'b111, 3'b000, 3'b111, 0, 0); check("first_gnt", gnt, 3'b001);
    check("first_oeb", gpio_oeb, 1);
    tick(3'b111, 3'b000, 3'b111, 0, 0); check("pad_0", {gpio_oeb, gpio_out}, 2'b00);
    tick(3'b111, 3'b001, 3'b111, 0, 0); check("pad_1", {gpio_oeb, gpio_out}, 2'b01);
    tick(3'b111, 3'b000, 3'b111, 0, 0); check("pad_2", {gpio_oeb, gpio_out}, 2'b00);
    tick(3'b110, 3'b000, 3'b111, 0, 0); check("dead", {busy, gpio_oeb, gnt}, {2'b11, 3'b000});
    tick(3'b110, 3'b000, 3'b111, 0, 0); check("gap_idle", gnt, 3'b000);
    tick(3'b110, 3'b000, 3'b111, 0, 0); check("rr_1", gnt, 3'b010);
    repeat (2) tick(3'b100, 3'b000, 3'b111, 0, 0);
    tick(3'b100, 3'b000, 3'b111, 0, 0); check("rr_2", gnt, 3'b100);
    repeat (2) tick(3'b001, 3'b000, 3'b111, 0, 0);
    tick(3'b001, 3'b000, 3'b111, 0, 0); check("rr_wrap", gnt, 3'b001);
    repeat (3) tick(3'b000, 3'b000, 3'b000, 0, 0);

    // Watchdog revocation and the block that follows it.
    tick(3'b010, 3'b000, 3'b010, 8, 0); check("tmo_gnt", gnt, 3'b010);
    for (int i = 0; i < 7; i++) begin
      tick(3'b010, 3'b000, 3'b010, 8, 0);
      check("tmo_hold", gnt, 3'b010);
    end
    tick(3'b010, 3'b000, 3'b010, 8, 0); check("tmo_fire", {tmo_evt, gnt}, {1'b1, 3'b000});
    tick(3'b010, 3'b000, 3'b010, 8, 0); check("tmo_pulse", tmo_evt, 0);
    repeat (10) tick(3'b010, 3'b000, 3'b010, 8, 0);
    check("tmo_blocked", gnt, 3'b000);
    tick(3'b000, 3'b000, 3'b010, 8, 0);
    tick(3'b010, 3'b000, 3'b010, 8, 0); check("tmo_regrant", gnt, 3'b010);
    repeat (3) tick(3'b000, 3'b000, 3'b000, 8, 0);

    // A release that lands on the timeout cycle.
    tick(3'b010, 3'b000, 3'b010, 8, 0);
    repeat (7) tick(3'b010, 3'b000, 3'b010, 8, 0);
    tick(3'b000, 3'b000, 3'b010, 8, 0);
    check("tie_release", {busy, tmo_evt, gnt}, {2'b10, 3'b000});
    tick(3'b010, 3'b000, 3'b010, 8, 0);
    tick(3'b010, 3'b000, 3'b010, 8, 0); check("tie_no_block", gnt, 3'b010);
    repeat (3) tick(3'b000, 3'b000, 3'b000, 0, 0);

    // Input synchroniser latency, then an asynchronous reset during a grant.
    tick(3'b001, 3'b000, 3'b001, 0, 1); check("sync_lat1", gpio_in, 0);
    tick(3'b001, 3'b000, 3'b001, 0, 1); check("sync_lat2", gpio_in, 1);
    tick(3'b001, 3'b001, 3'b001, 0, 1);
    check("pre_rst", {gpio_in, gpio_oeb, gnt}, {2'b10, 3'b001});
    core_rstn = 1'b0;
    #1;
    check("arst", {gpio_in, busy, gpio_oeb, gnt}, {3'b001, 3'b000});
    req = '0; out_val = '0; oe_val = '0; gpio_in_pad = 1'b0;
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    core_rstn = 1'b1;
    model_reset();

    // Random traffic with a small, changing watchdog limit.
    r_rand = '0; t_rand = '0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) t_rand = TMO_W'($urandom_range(0, 12));
      for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 7) == 0);
      r_rand = r_rand ^ flip;
      tick(r_rand, N'($urandom), N'($urandom), t_rand, 1'($urandom));
    end

    // Random traffic with the watchdog off, checking fairness.
    starve_en = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 7) == 0);
      r_rand = r_rand ^ flip;
      tick(r_rand, N'($urandom), N'($urandom), 0, 1'($urandom));
    end
    for (int i = 0; i < N; i++) check("starve_final", wait_c[i] < STARVE_BOUND, 1);
    starve_en = 1'b0;

    repeat (2) @(posedge core_clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    check("slot_ids", {REQ_CPU[1:0], REQ_LA[1:0], REQ_HK[1:0]}, 6'b00_01_10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
